// File: rtl/updown_pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updown_pulse_gen_if                                          |
// | Description : Button inputs, enable and strobe/level outputs of the        |
// |               up/down pulse generator.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface updown_pulse_gen_if;
    logic enable;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up_pulse;
    logic down_pulse;
    logic up_level;
    logic down_level;

    modport master (
        output enable, btn_up_raw, btn_down_raw,
        input  up_pulse, down_pulse, up_level, down_level
    );

    modport slave (
        input  enable, btn_up_raw, btn_down_raw,
        output up_pulse, down_pulse, up_level, down_level
    );
endinterface
`default_nettype wire

// File: rtl/updown_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updown_pulse_gen                                             |
// | Description : Synchronise, debounce and edge-detect UP/DOWN buttons into   |
// |               one-cycle strobes; optional hold-to-repeat when the macro    |
// |               UPDOWN_AUTO_REPEAT_EN is defined.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module updown_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  wire logic          clk,
    input  wire logic          sys_reset,
    updown_pulse_gen_if.slave  bus
);
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("updown_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // Bit 0 is the UP button, bit 1 is the DOWN button throughout.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_rise;
    logic [1:0] w_init;
    logic [1:0] w_rep;
    logic       r_up_pulse;
    logic       r_down_pulse;

    assign w_raw = {bus.btn_down_raw, bus.btn_up_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_differ;
        logic               w_toggle;

        assign w_differ    = r_sync2 ^ r_level;
        assign w_toggle    = w_differ && (r_cnt == c_CNT_LAST);
        assign w_rise[gi]  = w_toggle && !r_level;
        assign w_level[gi] = r_level;

        always_ff @(posedge clk) begin
            if (sys_reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                if (w_toggle) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else if (w_differ) begin
                    r_cnt   <= r_cnt + 1'b1;
                end else begin
                    r_cnt   <= '0;
                end
            end
        end
    end

    // A new press only counts when the other button is neither rising nor already held.
    assign w_init[0] = w_rise[0] && !w_rise[1] && !w_level[1] && bus.enable;
    assign w_init[1] = w_rise[1] && !w_rise[0] && !w_level[0] && bus.enable;

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    for (genvar gr = 0; gr < 2; gr++) begin : g_repeat
        localparam int c_OTHER = 1 - gr;
        logic               r_active;
        logic               r_first;
        logic [c_REP_W-1:0] r_timer;
        logic               w_hold;
        logic [c_REP_W-1:0] w_target;

        assign w_hold    = w_level[gr] && !w_level[c_OTHER] && bus.enable;
        assign w_target  = r_first ? c_DELAY_LAST : c_PERIOD_LAST;
        assign w_rep[gr] = r_active && w_hold && (r_timer == w_target);

        // Timer restarts from 0 on every issued pulse; any break in the hold disarms it.
        always_ff @(posedge clk) begin
            if (sys_reset) begin
                r_active <= 1'b0;
                r_first  <= 1'b0;
                r_timer  <= '0;
            end else if (w_init[gr]) begin
                r_active <= 1'b1;
                r_first  <= 1'b1;
                r_timer  <= '0;
            end else if (r_active && w_hold) begin
                if (w_rep[gr]) begin
                    r_first <= 1'b0;
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_active <= 1'b0;
                r_first  <= 1'b0;
                r_timer  <= '0;
            end
        end
    end
`else
    assign w_rep = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_up_pulse   <= w_init[0] || w_rep[0];
            r_down_pulse <= w_init[1] || w_rep[1];
        end
    end

    assign bus.up_pulse   = r_up_pulse;
    assign bus.down_pulse = r_down_pulse;
    assign bus.up_level   = w_level[0];
    assign bus.down_level = w_level[1];
endmodule
`default_nettype wire

// File: doc/updown_pulse_gen.md
Name: updown_pulse_gen

Overview:
- Front end for digit_selector: converts two raw, bouncing, asynchronous push-buttons (UP, DOWN) into clean single-cycle up_pulse/down_pulse strobes on the 50 MHz system clock.
- Per button: 2-FF synchroniser, counter-based debouncer, rising-edge detector.
- Adds enable gating, UP/DOWN conflict suppression, and an optional hold-to-repeat feature.
- Outputs connect directly to digit_selector's up_pulse/down_pulse inputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from its debounced state before that state flips. Minimum 1. Default is 20 ms at 50 MHz.
- REPEAT_DELAY, 25000000: cycles from the first pulse to the first auto-repeat pulse (500 ms). Used only with the optional feature.
- REPEAT_PERIOD, 10000000: cycles between successive auto-repeat pulses (200 ms). Used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz, all logic on rising edge
- sys_reset  in  1  synchronous, active-high reset
- enable  in  1  pulse output enable (driven by the same FSM signal as enable_digit_select)
- btn_up_raw  in  1  raw UP button, active-high, asynchronous
- btn_down_raw  in  1  raw DOWN button, active-high, asynchronous
- up_pulse  out  1  one-cycle increment strobe
- down_pulse  out  1  one-cycle decrement strobe
- up_level  out  1  debounced UP state
- down_level  out  1  debounced DOWN state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on sys_reset.
- Reset clears: synchroniser flops, debounce counters, up_level, down_level, up_pulse, down_pulse, repeat timers. All outputs read 0 in the cycle after the reset edge.
- Button held through reset: its level is 0 after reset, so it is debounced as a fresh press and produces one pulse once reset is released (if enable=1).
- Synchroniser: two flops per button. The raw value sampled at edge k appears at sync2 after edge k+1.
- Debouncer, per button:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - On each edge, if sync2 != level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync2 != level, level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles causes no level change.
- Pulse generation:
  - A 0->1 transition of up_level sets up_pulse on that same edge.
  - up_pulse is high for exactly one cycle.
  - A 1->0 transition of up_level produces no pulse.
  - DOWN behaves identically.
- Latency: a clean raw step sampled at edge 0 gives level=1 and pulse=1 after edge DEBOUNCE_CYCLES+1; the pulse drops after the next edge.
- Conflict rules:
  - If up_level and down_level rise on the same edge, neither pulses.
  - A rising edge of one button while the other's level is already 1 is suppressed.
  - up_pulse and down_pulse are never high in the same cycle.
- Enable: when enable=0, both pulses are forced to 0.
  - Debouncing and levels keep running while disabled.
  - Edges that occur while disabled are discarded, not queued.
  - Asserting enable while a button is held generates no pulse.
- Counter arithmetic: all counters saturate or clear; none wraps.

Optional Feature:
- Macro: UPDOWN_AUTO_REPEAT_EN.
- Defined:
  - Per-button repeat timer, width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - The timer starts at 0 on the edge that issues the initial pulse.
  - If the level stays 1, the other level stays 0 and enable=1, a repeat pulse is issued REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles after that.
  - Release, conflict or enable=0 clears the timer. Repetition resumes only after a new press.
- Not defined: exactly one pulse per debounced press. No repeat timers are synthesised.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, enable=1 unless stated):
- Reset/latency: sys_reset=1 for 3 cycles, then btn_up_raw=1 at edge 0 -> up_level=1 and up_pulse=1 after edge 5, up_pulse=0 after edge 6, down_pulse stays 0.
- Bounce rejection: btn_up_raw toggles 1,0,1,0 on alternate cycles for 12 cycles, then held 1 -> exactly one up_pulse, 5 edges after the final 0->1 sample. A 3-cycle glitch on down gives no down_pulse and down_level stays 0.
- Conflict: both raw inputs rise on the same edge -> no pulses, both levels 1. With up held and DOWN pressed later -> no down_pulse.
- Enable gating: enable=0, press and release DOWN -> no pulse, down_level follows. Press UP with enable=0, then raise enable while it is held -> no pulse.
- Digit_selector integration: 10 clean UP presses then 5 DOWN presses into digit_selector -> current_digit 0->9->0 (wrap), then 9,8,7,6,5.
- With UPDOWN_AUTO_REPEAT_EN: hold UP for 30 cycles after the first pulse at edge 5 -> pulses after edges 5, 15, 20, 25, 30, 35. Releasing clears the timer and gives no further pulses. Without the macro, the same stimulus gives a single pulse.
